// File: rtl/vga_line_buffer.sv
// Double-buffered scanline store: a producer fills one bank through valid/ready
// while the display reads the other bank; banks swap on the timing stage's line pulse.
module vga_line_buffer #(
    parameter int WIDTH  = 800,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [11:0]       wr_data,
    input  logic              line_swap,
    input  logic              frame_sync,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        r,
    output logic [3:0]        g,
    output logic [3:0]        b,
    output logic              underrun,
    output logic [CNT_W-1:0]  underrun_cnt,
    output logic              dbgState
);

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} wrState_t;

    localparam logic [ADDR_W:0] WIDTH_C = (ADDR_W+1)'(WIDTH);
    localparam logic [ADDR_W:0] LAST_C  = WIDTH_C - (ADDR_W+1)'(1);

    wrState_t          state;
    logic              wbank;
    logic              dispValid;
    logic [ADDR_W:0]   wcount;
    logic [11:0]       bank0 [WIDTH];
    logic [11:0]       bank1 [WIDTH];

    logic              xfer;
    logic              lastXfer;
    logic              rdInRange;
    logic [ADDR_W-1:0] rdIdx;
    logic [11:0]       rdWord;

    // Handshake: a pixel moves on every rising edge where wr_valid && wr_ready are
    // both high; wr_ready is registered and never depends on wr_valid.
    assign xfer      = wr_valid && wr_ready;
    assign lastXfer  = xfer && (wcount == LAST_C);
    assign rdInRange = {1'b0, rd_addr} < WIDTH_C;
    assign rdIdx     = rdInRange ? rd_addr : '0;
    assign rdWord    = wbank ? bank0[rdIdx] : bank1[rdIdx];
    assign dbgState  = (state == FULL);

    always_ff @(posedge clk) begin
        if (xfer) begin
            if (wbank) bank1[wcount[ADDR_W-1:0]] <= wr_data;
            else       bank0[wcount[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Read bank is ~wbank sampled before any swap at this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            {r, g, b} <= '0;
        end else if (rd_en && dispValid && rdInRange) begin
            {r, g, b} <= rdWord;
        end else begin
            {r, g, b} <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FILL;
            wbank        <= 1'b0;
            wcount       <= '0;
            dispValid    <= 1'b0;
            wr_ready     <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            underrun <= 1'b0;
            if (frame_sync) begin
                wcount    <= '0;
                state     <= FILL;
                dispValid <= 1'b0;
                wr_ready  <= 1'b1;
            end else if (line_swap && (state == FULL || lastXfer)) begin
                wbank     <= ~wbank;
                dispValid <= 1'b1;
                wcount    <= '0;
                state     <= FILL;
                wr_ready  <= 1'b1;
            end else begin
                // A refused swap blanks the next line but keeps the partial fill.
                if (line_swap) begin
                    underrun  <= 1'b1;
                    dispValid <= 1'b0;
                    if (underrun_cnt != '1)
                        underrun_cnt <= underrun_cnt + CNT_W'(1);
                end
                if (xfer)
                    wcount <= wcount + (ADDR_W+1)'(1);
                if (lastXfer) begin
                    state    <= FULL;
                    wr_ready <= 1'b0;
                end else begin
                    wr_ready <= (state == FILL);
                end
            end
        end
    end

endmodule
